ds_adc_mc: RTL and testbench

Multi-channel, parametrised first-order delta-sigma ADC front end. Each channel drives an external comparator/RC integrator through a 1-bit DAC flip-flop. One shared clock-enable divider serves all channels. Each channel has a boxcar (sinc1) decimator that turns its bitstream into signed DW-bit samples, and all channels are delivered together through a valid/ready output stage. It sits between the PMOD comparator inputs/DAC outputs and the downstream sample consumers, and replaces the single-channel, undecimated front end.

---
 rtl/ds_adc_mc.sv | 91 +++++++++
 tb/tb_ds_adc_mc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ds_adc_mc.sv
// ds_adc_mc: multi-channel first-order delta-sigma ADC front end with sinc1 decimation; define DS_ADC_SYNC2_EN for a two-flop comparator synchroniser
module ds_adc_mc #(
  parameter int CH  = 2,
  parameter int DIV = 100,
  parameter int OSR = 256,
  parameter int DW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    cmp_in,
  output logic [CH-1:0]    dac_drive,
  output logic [CH-1:0]    pdm,
  output logic             tick,
  output logic [CH*DW-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);
  localparam int LG = $clog2(OSR);
  localparam int SH = DW - 1 - LG;
  localparam int DVW = $clog2(DIV);
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};
  logic [DVW-1:0]   r_div;
  logic             r_tick;
  logic [CH-1:0]    r_dac;
  logic [LG-1:0]    r_wcnt;
  logic [LG:0]      r_ones [CH];
  logic [CH*DW-1:0] r_dout;
  logic             r_valid;
  logic             r_ovr;
  logic [CH-1:0]    w_cmp;
  logic [LG:0]      w_k [CH];
  logic [CH*DW-1:0] w_res;
  logic             w_load;
`ifdef DS_ADC_SYNC2_EN
  logic [CH-1:0] r_s1, r_s2;
  // two-flop synchroniser on the asynchronous comparator bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= cmp_in;
      r_s2 <= r_s1;
    end
  end
  assign w_cmp = r_s2;
`else
  assign w_cmp = cmp_in;
`endif
  assign w_load = r_tick && (r_wcnt == LG'(OSR - 1));
  // window count including this tick's bit, mapped to a signed code; k==OSR saturates, k<OSR maps as (k<<(SH+1)) - 2^(DW-1)
  always_comb begin
    w_res = '0;
    for (int c = 0; c < CH; c++) begin
      w_k[c] = r_ones[c] + (LG+1)'(r_dac[c]);
      w_res[c*DW +: DW] = w_k[c][LG] ? MAXV : ((DW'(w_k[c][LG-1:0]) << (SH + 1)) ^ MSB);
    end
  end
  // divider, modulator, accumulators and output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_dac   <= '0;
      r_wcnt  <= '0;
      r_ones  <= '{default: '0};
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_div  <= (r_div == DVW'(DIV - 1)) ? '0 : r_div + DVW'(1);
      r_tick <= (r_div == DVW'(DIV - 1));
      if (r_tick) begin
        r_dac  <= w_cmp;
        r_wcnt <= r_wcnt + LG'(1);
        for (int c = 0; c < CH; c++) r_ones[c] <= w_load ? '0 : w_k[c];
      end
      if (w_load) r_dout <= w_res;
      r_valid <= w_load | (r_valid & ~dout_ready);
      r_ovr   <= r_ovr | (w_load & r_valid & ~dout_ready);
    end
  end
  assign dac_drive  = r_dac;
  assign pdm        = r_dac;
  assign tick       = r_tick;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_ds_adc_mc.sv
// tb_ds_adc_mc: directed table-driven bench for ds_adc_mc with CH=2, DIV=4, OSR=8, DW=16
module tb_ds_adc_mc;
  localparam int CH = 2, DIV = 4, OSR = 8, DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] cmp_in = '0;
  logic [CH-1:0] dac_drive, pdm;
  logic tick, dout_valid, overrun;
  logic dout_ready = 1'b1;
  logic [CH*DW-1:0] dout;
  int n_chk = 0, n_fail = 0, cyc = 0, ntick = 0;
  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    int e0;
    int e1;
  } vec_t;
  vec_t tbl [7];
  ds_adc_mc #(.CH(CH), .DIV(DIV), .OSR(OSR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cmp_in(cmp_in), .dac_drive(dac_drive), .pdm(pdm),
    .tick(tick), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    chk("pdm_eq_dac", int'(pdm), int'(dac_drive));
  endtask
  function automatic int ch(input int i);
    return int'($signed(dout[i*DW +: DW]));
  endfunction
  task automatic wait_tick;
    int k;
    k = 0;
    do begin
      step;
      k++;
    end while (!tick && k < 2*DIV+2);
    chk("tick_seen", int'(tick), 1);
    ntick++;
  endtask
  task automatic to_tick(input int m);
    do wait_tick; while (ntick % OSR != m && n_fail < 50);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    cmp_in = '0;
    repeat (3) step;
    chk("rst_dout", int'(dout != 0), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_tick_dac", int'({tick, dac_drive}), 0);
    rst = 1'b0;
    cyc = 0;
    ntick = 0;
  endtask
  task automatic chk_out(input string name, input int e0, input int e1);
    chk({name, "_ch0"}, ch(0), e0);
    chk({name, "_ch1"}, ch(1), e1);
  endtask
  initial begin
    tbl[0] = '{8'b1111_1110, 8'b0000_0000, 24576, -32768};
    tbl[1] = '{8'b1111_1111, 8'b0000_0000, 32767, -32768};
    tbl[2] = '{8'b0101_0101, 8'b1111_1111, 0, 32767};
    tbl[3] = '{8'b0011_1111, 8'b1010_1010, 16384, 0};
    tbl[4] = '{8'b0000_0011, 8'b0111_1111, -16384, 24576};
    tbl[5] = '{8'b0000_0001, 8'b0000_0111, -24576, -8192};
    tbl[6] = '{8'b0001_1111, 8'b1111_1110, 8192, 24576};
    dout_ready = 1'b1;
    do_reset;
    for (int i = 0; i < DIV-1; i++) begin
      step;
      chk("pre_tick_quiet", int'({tick, dout_valid, overrun, dac_drive, |dout}), 0);
    end
    for (int n = 1; n <= OSR*7; n++) begin
      wait_tick;
      if (n == 1) chk("first_tick_cycle", cyc, DIV);
      if (n / OSR < 7) cmp_in = {tbl[n/OSR].p1[n%OSR], tbl[n/OSR].p0[n%OSR]};
      step;
      if (n % OSR == 0) begin
        if (n == OSR) chk("first_valid_cycle", cyc, OSR*DIV+1);
        chk("win_valid", int'(dout_valid), 1);
        chk_out("win", tbl[n/OSR-1].e0, tbl[n/OSR-1].e1);
        step;
        chk("win_valid_pulse", int'(dout_valid), 0);
        chk("win_no_ovr", int'(overrun), 0);
      end
    end
    cmp_in = 2'b01;
    dout_ready = 1'b0;
    to_tick(0);
    step;
    chk("ovr_load1_valid", int'(dout_valid), 1);
    chk("ovr_load1_flag", int'(overrun), 0);
    chk_out("ovr_load1", 24576, -24576);
    to_tick(4);
    chk_out("ovr_hold", 24576, -24576);
    to_tick(0);
    step;
    chk("ovr_load2_valid", int'(dout_valid), 1);
    chk("ovr_load2_flag", int'(overrun), 1);
    chk_out("ovr_load2", 32767, -32768);
    dout_ready = 1'b1;
    step;
    dout_ready = 1'b0;
    chk("ovr_ready_clears", int'(dout_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    do_reset;
    cmp_in = 2'b01;
    dout_ready = 1'b0;
    to_tick(0);
    step;
    chk("lc_first_valid", int'(dout_valid), 1);
    chk_out("lc_first", 24576, -32768);
    to_tick(0);
    dout_ready = 1'b1;
    step;
    dout_ready = 1'b0;
    chk("lc_valid_kept", int'(dout_valid), 1);
    chk("lc_no_ovr", int'(overrun), 0);
    chk_out("lc_new", 32767, -32768);
    step;
    chk("lc_valid_holds", int'(dout_valid), 1);
    to_tick(6);
    rst = 1'b1;
    step;
    chk("mid_rst_drop", int'(dout_valid), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    chk("mid_rst_dout", int'(dout != 0), 0);
    rst = 1'b0;
    cyc = 0;
    ntick = 0;
    dout_ready = 1'b1;
    to_tick(0);
    step;
    chk("mid_rst_cycle", cyc, OSR*DIV+1);
    chk("mid_rst_valid", int'(dout_valid), 1);
    chk_out("mid_rst", 24576, -32768);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
